// File: rtl/lpv_pkg.sv
// Shared low-power types and defaults: sequencer state encoding and timing defaults.
package lpv_pkg;

  typedef enum logic [2:0] {
    ST_ON      = 3'd0,
    ST_ISO     = 3'd1,
    ST_SAVE    = 3'd2,
    ST_PSW_OFF = 3'd3,
    ST_OFF     = 3'd4,
    ST_PSW_ON  = 3'd5,
    ST_RESTORE = 3'd6,
    ST_DEISO   = 3'd7
  } pwr_state_t;

  localparam int ISO_DLY_DEF     = 2;
  localparam int PSW_TIMEOUT_DEF = 15;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pwr_ctrl_if.sv
// Control/status bundle between the tx power domain, its power switch and the sequencer.
interface pwr_ctrl_if;
  import lpv_pkg::*;

  logic       idle;
  logic       wake_req;
  logic       psw_ack;
  logic       psw_en;
  logic       iso_en;
  logic       save;
  logic       restore;
  logic       pwr_up;
  logic       pwr_err;
  pwr_state_t state;

  modport master (
    output idle, wake_req, psw_ack,
    input  psw_en, iso_en, save, restore, pwr_up, pwr_err, state
  );

  modport slave (
    input  idle, wake_req, psw_ack,
    output psw_en, iso_en, save, restore, pwr_up, pwr_err, state
  );

endinterface

// File: rtl/pwr_ctrl.sv
// Tx power-domain sequencer: isolate -> save -> switch off, and switch on -> restore -> de-isolate.
// State | meaning: ON usable, ISO clamping, SAVE retention pulse, PSW_OFF rail dropping,
// OFF domain down, PSW_ON rail rising, RESTORE retention pulse, DEISO releasing clamps.
module pwr_ctrl
  import lpv_pkg::*;
#(
  parameter int ISO_DLY     = ISO_DLY_DEF,
  parameter int PSW_TIMEOUT = PSW_TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  pwr_ctrl_if.slave    bus
);

  localparam int CNT_MAX = max_int(ISO_DLY, PSW_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_DLY - 1);
  localparam logic [CNT_W-1:0] PSW_LAST = CNT_W'(PSW_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);

  pwr_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_psw_en, r_iso_en, r_save, r_restore, r_pwr_up, r_pwr_err;

  pwr_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_psw_en_nxt, w_iso_en_nxt, w_save_nxt, w_restore_nxt;
  logic             w_pwr_up_nxt, w_pwr_err_nxt;
  logic             w_iso_done, w_psw_to;

  assign w_iso_done = (r_cnt == ISO_LAST);
  assign w_psw_to   = (r_cnt == PSW_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_ON;
      r_cnt     <= '0;
      r_psw_en  <= 1'b1;
      r_iso_en  <= 1'b0;
      r_save    <= 1'b0;
      r_restore <= 1'b0;
      r_pwr_up  <= 1'b1;
      r_pwr_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_psw_en  <= w_psw_en_nxt;
      r_iso_en  <= w_iso_en_nxt;
      r_save    <= w_save_nxt;
      r_restore <= w_restore_nxt;
      r_pwr_up  <= w_pwr_up_nxt;
      r_pwr_err <= w_pwr_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ON:      if (bus.idle && !bus.wake_req) w_state_nxt = ST_ISO;
      ST_ISO:     if (bus.wake_req)              w_state_nxt = ST_DEISO;
                  else if (w_iso_done)           w_state_nxt = ST_SAVE;
      ST_SAVE:                                   w_state_nxt = ST_PSW_OFF;
      ST_PSW_OFF: if (!bus.psw_ack || w_psw_to)  w_state_nxt = ST_OFF;
      ST_OFF:     if (bus.wake_req)              w_state_nxt = ST_PSW_ON;
      ST_PSW_ON:  if (bus.psw_ack || w_psw_to)   w_state_nxt = ST_RESTORE;
      ST_RESTORE:                                w_state_nxt = ST_DEISO;
      ST_DEISO:   if (w_iso_done)                w_state_nxt = ST_ON;
      default:                                   w_state_nxt = ST_ON;
    endcase
  end

  // Outputs are a function of the state being entered, so they flip on the same edge.
  always_comb begin
    w_psw_en_nxt  = !((w_state_nxt == ST_PSW_OFF) || (w_state_nxt == ST_OFF));
    w_iso_en_nxt  = (w_state_nxt != ST_ON);
    w_pwr_up_nxt  = (w_state_nxt == ST_ON);
    w_save_nxt    = (w_state_nxt == ST_SAVE);
    w_restore_nxt = (w_state_nxt == ST_RESTORE);
    w_pwr_err_nxt = r_pwr_err
                  | ((r_state == ST_PSW_OFF) && bus.psw_ack  && w_psw_to)
                  | ((r_state == ST_PSW_ON)  && !bus.psw_ack && w_psw_to);
    if (w_state_nxt != r_state)
      w_cnt_nxt = '0;
    else if (r_cnt == CNT_SAT)
      w_cnt_nxt = r_cnt;
    else
      w_cnt_nxt = r_cnt + 1'b1;
  end

  assign bus.psw_en  = r_psw_en;
  assign bus.iso_en  = r_iso_en;
  assign bus.save    = r_save;
  assign bus.restore = r_restore;
  assign bus.pwr_up  = r_pwr_up;
  assign bus.pwr_err = r_pwr_err;
  assign bus.state   = r_state;

endmodule

// File: tb/tb_pwr_ctrl.sv
// Directed bench for pwr_ctrl: down/up sequences, abort, timeouts, reset mid-sequence, invariants.
module tb_pwr_ctrl;
  import lpv_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  pwr_ctrl_if ifc ();

  pwr_ctrl #(.ISO_DLY(2), .PSW_TIMEOUT(15)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input pwr_state_t exp);
    chk(tag, 32'(ifc.state), 32'(exp));
  endtask

  // Invariants sampled on every falling edge, including during reset.
  always @(negedge clk) begin
    chk("inv_pwrup", 32'(!ifc.pwr_up || (!ifc.iso_en && ifc.psw_en)), 32'd1);
    chk("inv_pulses", 32'(!(ifc.save && ifc.restore)), 32'd1);
    chk("inv_pswoff", 32'(ifc.psw_en || ifc.state == ST_PSW_OFF || ifc.state == ST_OFF), 32'd1);
    chk("inv_iso", 32'(ifc.psw_en || ifc.iso_en), 32'd1);
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    ifc.idle = 1'b0;
    ifc.wake_req = 1'b0;
    ifc.psw_ack = 1'b1;
    tick(3);
    chk_st("rst_state", ST_ON);
    chk("rst_psw_en", 32'(ifc.psw_en), 1);
    chk("rst_iso_en", 32'(ifc.iso_en), 0);
    chk("rst_pwr_up", 32'(ifc.pwr_up), 1);
    chk("rst_pwr_err", 32'(ifc.pwr_err), 0);
    reset = 1'b0;

    // T1: idle low keeps the domain on
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_st("t1_state", ST_ON);
      chk("t1_pwr_up", 32'(ifc.pwr_up), 1);
      chk("t1_psw_en", 32'(ifc.psw_en), 1);
      chk("t1_iso_en", 32'(ifc.iso_en), 0);
    end

    // T2: shutdown, ack drops 3 cycles after psw_en
    ifc.idle = 1'b1;
    tick(); chk_st("t2_e1_state", ST_ISO);
    chk("t2_e1_iso", 32'(ifc.iso_en), 1);
    chk("t2_e1_pwr_up", 32'(ifc.pwr_up), 0);
    tick(); chk_st("t2_e2_state", ST_ISO);
    chk("t2_e2_save", 32'(ifc.save), 0);
    tick(); chk_st("t2_e3_state", ST_SAVE);
    chk("t2_e3_save", 32'(ifc.save), 1);
    chk("t2_e3_psw_en", 32'(ifc.psw_en), 1);
    tick(); chk_st("t2_e4_state", ST_PSW_OFF);
    chk("t2_e4_save", 32'(ifc.save), 0);
    chk("t2_e4_psw_en", 32'(ifc.psw_en), 0);
    tick(3); chk_st("t2_e7_state", ST_PSW_OFF);
    ifc.psw_ack = 1'b0;
    tick(); chk_st("t2_e8_state", ST_OFF);
    chk("t2_e8_err", 32'(ifc.pwr_err), 0);
    tick(2); chk_st("t2_off_hold", ST_OFF);

    // T3: wake, ack rises 3 cycles after psw_en
    ifc.idle = 1'b0;
    ifc.wake_req = 1'b1;
    tick(); chk_st("t3_e1_state", ST_PSW_ON);
    chk("t3_e1_psw_en", 32'(ifc.psw_en), 1);
    ifc.wake_req = 1'b0;
    tick(3); chk_st("t3_e4_state", ST_PSW_ON);
    chk("t3_e4_restore", 32'(ifc.restore), 0);
    ifc.psw_ack = 1'b1;
    tick(); chk_st("t3_e5_state", ST_RESTORE);
    chk("t3_e5_restore", 32'(ifc.restore), 1);
    tick(); chk_st("t3_e6_state", ST_DEISO);
    chk("t3_e6_restore", 32'(ifc.restore), 0);
    tick(); chk("t3_e7_pwr_up", 32'(ifc.pwr_up), 0);
    chk("t3_e7_iso", 32'(ifc.iso_en), 1);
    tick(); chk_st("t3_e8_state", ST_ON);
    chk("t3_e8_pwr_up", 32'(ifc.pwr_up), 1);
    chk("t3_e8_iso", 32'(ifc.iso_en), 0);

    // T4: wake during ISO aborts without save
    ifc.idle = 1'b1;
    tick(); chk_st("t4_e1_state", ST_ISO);
    ifc.wake_req = 1'b1;
    tick(); chk_st("t4_e2_state", ST_DEISO);
    chk("t4_e2_save", 32'(ifc.save), 0);
    chk("t4_e2_psw_en", 32'(ifc.psw_en), 1);
    ifc.wake_req = 1'b0;
    ifc.idle = 1'b0;
    tick(); chk_st("t4_e3_state", ST_DEISO);
    chk("t4_e3_save", 32'(ifc.save), 0);
    tick(); chk_st("t4_e4_state", ST_ON);
    chk("t4_e4_pwr_up", 32'(ifc.pwr_up), 1);

    // idle together with wake: wake wins
    ifc.idle = 1'b1;
    ifc.wake_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_st("onwake_state", ST_ON);
    end
    ifc.wake_req = 1'b0;

    // T5: ack stuck high -> switch-off timeout
    tick(4); chk_st("t5_e4_state", ST_PSW_OFF);
    tick(14); chk_st("t5_e18_state", ST_PSW_OFF);
    chk("t5_e18_err", 32'(ifc.pwr_err), 0);
    tick(); chk_st("t5_e19_state", ST_OFF);
    chk("t5_e19_err", 32'(ifc.pwr_err), 1);
    tick(); chk_st("t5_off_idle", ST_OFF);
    ifc.idle = 1'b0;
    ifc.wake_req = 1'b1;
    tick(); chk_st("t5_w1_state", ST_PSW_ON);
    ifc.wake_req = 1'b0;
    tick(); chk_st("t5_w2_state", ST_RESTORE);
    tick(2); chk("t5_w4_pwr_up", 32'(ifc.pwr_up), 0);
    tick(); chk_st("t5_w5_state", ST_ON);
    chk("t5_w5_pwr_up", 32'(ifc.pwr_up), 1);
    chk("t5_w5_err", 32'(ifc.pwr_err), 1);

    // T6: reset while in PSW_OFF
    ifc.idle = 1'b1;
    tick(4); chk("t6_psw_en_lo", 32'(ifc.psw_en), 0);
    tick();
    reset = 1'b1;
    #1;
    chk_st("t6_async_state", ST_ON);
    chk("t6_async_psw_en", 32'(ifc.psw_en), 1);
    chk("t6_async_iso", 32'(ifc.iso_en), 0);
    chk("t6_async_err", 32'(ifc.pwr_err), 0);
    ifc.idle = 1'b0;
    tick();
    chk("t6_pwr_up", 32'(ifc.pwr_up), 1);
    reset = 1'b0;
    tick(); chk_st("t6_post_state", ST_ON);
    chk("t6_post_err", 32'(ifc.pwr_err), 0);

    // T7: ack never rises on wake -> switch-on timeout
    ifc.idle = 1'b1;
    tick(4); chk_st("t7_e4_state", ST_PSW_OFF);
    ifc.psw_ack = 1'b0;
    tick(); chk_st("t7_e5_state", ST_OFF);
    chk("t7_e5_err", 32'(ifc.pwr_err), 0);
    ifc.idle = 1'b0;
    ifc.wake_req = 1'b1;
    tick(); chk_st("t7_w1_state", ST_PSW_ON);
    ifc.wake_req = 1'b0;
    tick(14); chk_st("t7_w15_state", ST_PSW_ON);
    chk("t7_w15_err", 32'(ifc.pwr_err), 0);
    tick(); chk_st("t7_w16_state", ST_RESTORE);
    chk("t7_w16_restore", 32'(ifc.restore), 1);
    chk("t7_w16_err", 32'(ifc.pwr_err), 1);
    ifc.psw_ack = 1'b1;
    tick(3); chk_st("t7_w19_state", ST_ON);
    chk("t7_w19_pwr_up", 32'(ifc.pwr_up), 1);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
